multdiv_sequencer: RTL and testbench
====================================

Name: multdiv_sequencer

Overview:
- Execute-stage controller for multi-cycle signed MUL and DIV.
- Detects a mul/div instruction in X and stalls the pipeline while an iterative datapath runs for 32 iterations.
- Presents a one-cycle writeback bundle at the end.
- On overflow or divide-by-zero, the writeback is redirected to the status register. Its value is the rstatus code produced alongside it by the overflow/status block: 4 for mul, 5 for div.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH
STATUS_REG, 30, register index written on exception

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
valid_x  in  1  X-stage instruction is valid
flush_x  in  1  abort in-flight operation (branch/jump squash)
op  in  5  X-stage opcode
alu_op  in  5  X-stage ALU opcode
data_a  in  WIDTH  operand A (signed)
data_b  in  WIDTH  operand B (signed)
rd  in  5  destination register
rstatus_in  in  32  status code from overflow/status block for this instruction
stall  out  1  freeze PC, F/D and D/X latches
md_ready  out  1  one-cycle writeback-valid pulse
md_result  out  WIDTH  quotient/product, or latched rstatus on exception
md_rd  out  5  rd, or STATUS_REG on exception
md_we  out  1  register write enable for the writeback bundle
md_exception  out  1  overflow or divide-by-zero occurred

Behaviour:
- Decode: mul = op 00000 & alu_op 00110; div = op 00000 & alu_op 00111. start = valid_x & (mul|div) & state==IDLE & ~flush_x.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: on start, latch |a|, |b|, sign bits, rd and rstatus_in; clear counter; go to MUL or DIV.
  - Exception: div with data_b==0 goes straight to DONE with exception=1.
- stall = start | (state==MUL) | (state==DIV). stall is low in IDLE without start, and low in DONE.
- MUL:
  - Unsigned shift-add over the magnitudes, one bit per cycle, 32 cycles, 64-bit accumulator.
  - Then apply sign (sa^sb) by two's complement.
  - Overflow when bits [63:31] of the signed product are not all equal.
- DIV:
  - Restoring division on magnitudes, one quotient bit per cycle, 32 cycles.
  - Quotient negated when sa^sb; truncates toward zero; remainder discarded.
  - -2^31 / -1 flags overflow.
- Latency with start in cycle T:
  - MUL/DIV occupy T+1..T+32; DONE at T+33; stall high T..T+32.
  - Divide-by-zero: DONE at T+1; stall high in T only.
- DONE (exactly one cycle, then IDLE):
  - md_ready=1.
  - On exception: md_result=latched rstatus, md_rd=STATUS_REG, md_we=1, md_exception=1.
  - Otherwise: md_result=result, md_rd=rd, md_we=(rd!=0).
- start is sampled only in IDLE. In DONE the same instruction is still in X and must not retrigger.
- flush_x in MUL/DIV: go to IDLE next cycle, no md_ready, no write. flush_x in IDLE suppresses start.
- md_ready, md_we and md_exception are low in every state except DONE. md_result and md_rd hold their last value outside DONE.
- Reset:
  - Synchronous, takes priority over everything including mid-operation.
  - State=IDLE, counter=0, all outputs 0 (stall, md_ready, md_we, md_exception, md_result, md_rd).
  - In-flight operation abandoned with no writeback.
- A zero operand with a nonzero divisor is normal: 0*x=0, 0/x=0.

Decomposition:
- Shared package md_pkg holds:
  - opcode constants OP_RTYPE=00000, ALU_MUL=00110, ALU_DIV=00111
  - status codes RSTATUS_MUL=4, RSTATUS_DIV=5
  - FSM state encoding
- One sub-module, md_iter_core: the 64-bit accumulator/remainder datapath plus the 5-bit iteration counter. It takes a mode select and a step enable, and outputs a done flag and the raw magnitude result.
- FSM, sign handling, exception muxing and output registers stay in multdiv_sequencer.

Test Plan:
- mul 7 * -6, rd=5, start at T -> stall high T..T+32; at T+33 md_ready=1, md_result=0xFFFFFFD6 (-42), md_rd=5, md_we=1, md_exception=0.
- div -100 / 7, rd=3 -> DONE at T+33, md_result=0xFFFFFFF2 (-14), md_we=1.
- mul 0x00010000 * 0x00010000 with rstatus_in=4 -> md_exception=1, md_rd=30, md_result=4, md_we=1.
- div 5 / 0 with rstatus_in=5 -> stall only in T, md_ready at T+1, md_rd=30, md_result=5.
- div 0x80000000 / 0xFFFFFFFF with rstatus_in=5 -> overflow: md_rd=30, md_result=5, md_exception=1.
- mul started, flush_x at T+10 -> IDLE at T+11, no md_ready.
- Separate run: mul started, reset at T+20 -> all outputs 0 next cycle and no writeback.
- Back-to-back mul then div -> div start accepted in the IDLE cycle after DONE, never in DONE.
- mul with rd=0 -> md_we=0 with md_ready=1.

Source files
------------

// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Package  : md_pkg
// Brief    : Shared opcodes, status codes and FSM encoding for multdiv_sequencer
// Revision : 1.0
// ============================================================================
package md_pkg;

    localparam logic [4:0]  OP_RTYPE    = 5'b00000;
    localparam logic [4:0]  ALU_MUL     = 5'b00110;
    localparam logic [4:0]  ALU_DIV     = 5'b00111;

    // Codes the overflow/status block places on rstatus_in.
    localparam logic [31:0] RSTATUS_MUL = 32'd4;
    localparam logic [31:0] RSTATUS_DIV = 32'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

endpackage
`default_nettype wire

// File: rtl/md_iter_core.sv
`default_nettype none
// ============================================================================
// Module   : md_iter_core
// Brief    : One-bit-per-cycle shift-add multiplier / restoring divider on magnitudes
// Revision : 1.0
// ============================================================================
module md_iter_core
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_mode_div,
    input  logic [WIDTH-1:0]   i_mag_a,
    input  logic [WIDTH-1:0]   i_mag_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_result
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_acc_q, w_acc_d;
    logic [WIDTH-1:0]   r_opb_q, w_opb_d;
    logic               r_mode_q, w_mode_d;
    logic [CNT_W-1:0]   r_cnt_q, w_cnt_d;

    logic [WIDTH:0]     w_add;
    logic [2*WIDTH-1:0] w_shl;
    logic [WIDTH:0]     w_sub;

    always_comb begin
        w_acc_d  = r_acc_q;
        w_opb_d  = r_opb_q;
        w_mode_d = r_mode_q;
        w_cnt_d  = r_cnt_q;

        // Multiply: upper half accumulates, multiplier bits drain out of the lower half.
        w_add = {1'b0, r_acc_q[2*WIDTH-1:WIDTH]}
              + (r_acc_q[0] ? {1'b0, r_opb_q} : {(WIDTH+1){1'b0}});
        // Divide: upper half is the partial remainder, quotient bits enter at bit 0.
        w_shl = {r_acc_q[2*WIDTH-2:0], 1'b0};
        w_sub = {1'b0, w_shl[2*WIDTH-1:WIDTH]} - {1'b0, r_opb_q};

        if (i_load) begin
            w_acc_d  = {{WIDTH{1'b0}}, i_mag_a};
            w_opb_d  = i_mag_b;
            w_mode_d = i_mode_div;
            w_cnt_d  = '0;
        end else if (i_step) begin
            if (r_mode_q) begin
                w_acc_d = w_sub[WIDTH] ? w_shl
                                       : {w_sub[WIDTH-1:0], w_shl[WIDTH-1:1], 1'b1};
            end else begin
                w_acc_d = {w_add, r_acc_q[WIDTH-1:1]};
            end
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_q  <= '0;
            r_opb_q  <= '0;
            r_mode_q <= 1'b0;
            r_cnt_q  <= '0;
        end else begin
            r_acc_q  <= w_acc_d;
            r_opb_q  <= w_opb_d;
            r_mode_q <= w_mode_d;
            r_cnt_q  <= w_cnt_d;
        end
    end

    assign o_done   = i_step & (r_cnt_q == LAST);
    assign o_result = r_acc_q;

endmodule
`default_nettype wire

// File: rtl/multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_sequencer
// Brief    : X-stage controller for iterative signed MUL/DIV with stall and writeback
// Revision : 1.0
// ============================================================================
module multdiv_sequencer
    import md_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int STATUS_REG = 30
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid_x,
    input  logic             flush_x,
    input  logic [4:0]       op,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [4:0]       rd,
    input  logic [31:0]      rstatus_in,
    output logic             stall,
    output logic             md_ready,
    output logic [WIDTH-1:0] md_result,
    output logic [4:0]       md_rd,
    output logic             md_we,
    output logic             md_exception
);

    md_state_e          r_state_q, w_state_d;
    logic               r_neg_q, w_neg_d;
    logic               r_is_div_q, w_is_div_d;
    logic               r_dz_q, w_dz_d;
    logic [4:0]         r_rd_q, w_rd_d;
    logic [31:0]        r_rstatus_q, w_rstatus_d;
    logic [WIDTH-1:0]   r_md_result_q, w_md_result_d;
    logic [4:0]         r_md_rd_q, w_md_rd_d;

    logic               w_is_mul, w_is_div, w_start, w_step;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic               w_core_done;
    logic [2*WIDTH-1:0] w_core_result;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot_mag, w_quot, w_value;
    logic               w_mul_ovf, w_div_ovf, w_exc;

    assign w_is_mul = (op == OP_RTYPE) && (alu_op == ALU_MUL);
    assign w_is_div = (op == OP_RTYPE) && (alu_op == ALU_DIV);
    assign w_start  = valid_x & (w_is_mul | w_is_div) & (r_state_q == ST_IDLE) & ~flush_x;
    assign w_step   = ((r_state_q == ST_MUL) || (r_state_q == ST_DIV)) & ~flush_x;
    assign w_mag_a  = data_a[WIDTH-1] ? -data_a : data_a;
    assign w_mag_b  = data_b[WIDTH-1] ? -data_b : data_b;

    md_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clock),
        .rst        (reset),
        .i_load     (w_start),
        .i_step     (w_step),
        .i_mode_div (w_is_div),
        .i_mag_a    (w_mag_a),
        .i_mag_b    (w_mag_b),
        .o_done     (w_core_done),
        .o_result   (w_core_result)
    );

    // Signed product fits only if everything from bit WIDTH-1 upward is sign extension.
    assign w_prod     = r_neg_q ? -w_core_result : w_core_result;
    assign w_mul_ovf  = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));
    assign w_quot_mag = w_core_result[WIDTH-1:0];
    assign w_quot     = r_neg_q ? -w_quot_mag : w_quot_mag;
    // A positive quotient with the top magnitude bit set is only reachable as MIN / -1.
    assign w_div_ovf  = ~r_neg_q & w_quot_mag[WIDTH-1];
    assign w_exc      = r_dz_q | (r_is_div_q ? w_div_ovf : w_mul_ovf);
    assign w_value    = r_is_div_q ? w_quot : w_prod[WIDTH-1:0];

    always_comb begin
        w_state_d     = r_state_q;
        w_neg_d       = r_neg_q;
        w_is_div_d    = r_is_div_q;
        w_dz_d        = r_dz_q;
        w_rd_d        = r_rd_q;
        w_rstatus_d   = r_rstatus_q;
        w_md_result_d = r_md_result_q;
        w_md_rd_d     = r_md_rd_q;
        stall         = w_start;
        md_ready      = 1'b0;
        md_we         = 1'b0;
        md_exception  = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (w_start) begin
                    w_neg_d     = data_a[WIDTH-1] ^ data_b[WIDTH-1];
                    w_is_div_d  = w_is_div;
                    w_dz_d      = w_is_div & (data_b == '0);
                    w_rd_d      = rd;
                    w_rstatus_d = rstatus_in;
                    if (w_is_div && (data_b == '0)) w_state_d = ST_DONE;
                    else if (w_is_div)              w_state_d = ST_DIV;
                    else                            w_state_d = ST_MUL;
                end
            end
            ST_MUL, ST_DIV: begin
                stall = 1'b1;
                if (flush_x)          w_state_d = ST_IDLE;
                else if (w_core_done) w_state_d = ST_DONE;
            end
            ST_DONE: begin
                md_ready      = 1'b1;
                md_exception  = w_exc;
                md_we         = w_exc | (r_rd_q != 5'd0);
                w_md_result_d = w_exc ? WIDTH'(r_rstatus_q) : w_value;
                w_md_rd_d     = w_exc ? 5'(STATUS_REG) : r_rd_q;
                w_state_d     = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    assign md_result = w_md_result_d;
    assign md_rd     = w_md_rd_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q     <= ST_IDLE;
            r_neg_q       <= 1'b0;
            r_is_div_q    <= 1'b0;
            r_dz_q        <= 1'b0;
            r_rd_q        <= '0;
            r_rstatus_q   <= '0;
            r_md_result_q <= '0;
            r_md_rd_q     <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_neg_q       <= w_neg_d;
            r_is_div_q    <= w_is_div_d;
            r_dz_q        <= w_dz_d;
            r_rd_q        <= w_rd_d;
            r_rstatus_q   <= w_rstatus_d;
            r_md_result_q <= w_md_result_d;
            r_md_rd_q     <= w_md_rd_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_sequencer
// Brief    : Scoreboard bench for multdiv_sequencer with an arithmetic reference model
// Revision : 1.0
// ============================================================================
module tb_multdiv_sequencer;
    import md_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        valid_x = 1'b0;
    logic        flush_x = 1'b0;
    logic [4:0]  op = 5'd0;
    logic [4:0]  alu_op = 5'd0;
    logic [31:0] data_a = 32'd0;
    logic [31:0] data_b = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic [31:0] rstatus_in = 32'd0;
    logic        stall, md_ready, md_we, md_exception;
    logic [31:0] md_result;
    logic [4:0]  md_rd;

    multdiv_sequencer #(.WIDTH(32), .STATUS_REG(30)) dut (
        .clock        (clock),
        .reset        (reset),
        .valid_x      (valid_x),
        .flush_x      (flush_x),
        .op           (op),
        .alu_op       (alu_op),
        .data_a       (data_a),
        .data_b       (data_b),
        .rd           (rd),
        .rstatus_in   (rstatus_in),
        .stall        (stall),
        .md_ready     (md_ready),
        .md_result    (md_result),
        .md_rd        (md_rd),
        .md_we        (md_we),
        .md_exception (md_exception)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        logic        exc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    logic        rst_seen = 1'b0;
    logic        mon_en   = 1'b0;
    logic [31:0] last_res = 32'd0;
    logic [4:0]  last_rd  = 5'd0;

    always @(posedge clock) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    task automatic chk(input bit ok, input string what, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", what, act, expv, cyc);
    endtask

    // Reference: plain signed arithmetic, overflow = result outside the 32-bit signed range.
    function automatic void ref_model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                      input logic [4:0] rd_i, input logic [31:0] rstat,
                                      output exp_t e, output int lat);
        longint sa, sb, r;
        bit     exc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lat = 33;
        exc = 1'b0;
        r   = 0;
        if (!is_div)     r = sa * sb;
        else if (b == 0) begin exc = 1'b1; lat = 1; end
        else             r = sa / sb;
        if (r > 64'sd2147483647 || r < -64'sd2147483648) exc = 1'b1;
        e.cyc = 0;
        e.res = exc ? rstat : r[31:0];
        e.rd  = exc ? 5'd30 : rd_i;
        e.we  = exc || (rd_i != 5'd0);
        e.exc = exc;
    endfunction

    // Monitor: every writeback must match the head of the scoreboard; between
    // writebacks the bundle must be quiet and hold the last presented values.
    always @(negedge clock) begin
        #2;
        if (rst_seen) begin
            sb_q.delete();
            last_res = 32'd0;
            last_rd  = 5'd0;
        end
        if (mon_en) begin
            if (md_ready) begin
                if (sb_q.size() == 0) begin
                    chk(1'b0, "unexpected_writeback", 64'({md_rd, md_result}), 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk({16'(cyc), md_result, md_rd, md_we, md_exception} ==
                        {16'(mon_e.cyc), mon_e.res, mon_e.rd, mon_e.we, mon_e.exc},
                        "writeback{cyc,res,rd,we,exc}",
                        64'({16'(cyc), md_result, md_rd, md_we, md_exception}),
                        64'({16'(mon_e.cyc), mon_e.res, mon_e.rd, mon_e.we, mon_e.exc}));
                    last_res = mon_e.res;
                    last_rd  = mon_e.rd;
                end
            end else begin
                chk({md_we, md_exception, md_rd, md_result} == {2'b00, last_rd, last_res},
                    "quiet_hold{we,exc,rd,res}",
                    64'({md_we, md_exception, md_rd, md_result}),
                    64'({2'b00, last_rd, last_res}));
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following the op.
    task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd_i, input int flush_at, input int reset_at);
        exp_t e;
        int   lat, t0, abort_at;
        valid_x    = 1'b1;
        flush_x    = 1'b0;
        op         = OP_RTYPE;
        alu_op     = is_div ? ALU_DIV : ALU_MUL;
        data_a     = a;
        data_b     = b;
        rd         = rd_i;
        rstatus_in = is_div ? RSTATUS_DIV : RSTATUS_MUL;
        t0         = cyc;
        ref_model(is_div, a, b, rd_i, rstatus_in, e, lat);
        abort_at   = (flush_at >= 0) ? flush_at : reset_at;
        if (abort_at < 0) begin
            e.cyc = t0 + lat;
            sb_q.push_back(e);
        end
        for (int k = 0; k <= lat; k++) begin
            if (abort_at >= 0 && k == abort_at + 1) begin
                valid_x = 1'b0;
                flush_x = 1'b0;
                reset   = 1'b0;
                #1;
                if (reset_at >= 0)
                    chk({stall, md_ready, md_we, md_exception, md_rd, md_result} == 41'd0,
                        "after_reset_all_zero",
                        64'({stall, md_ready, md_we, md_exception, md_rd, md_result}), 64'd0);
                else
                    chk({stall, md_ready} == 2'b00, "after_flush{stall,ready}",
                        64'({stall, md_ready}), 64'd0);
                @(negedge clock);
                break;
            end
            if (k == flush_at) flush_x = 1'b1;
            if (k == reset_at) reset = 1'b1;
            #1;
            chk(stall == (k < lat), $sformatf("stall@T+%0d", k), 64'(stall), 64'(k < lat));
            @(negedge clock);
        end
        valid_x = 1'b0;
        flush_x = 1'b0;
    endtask

    // Idle cycles that must never start an operation.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 2))
                0: begin valid_x = 1'b0; flush_x = 1'b0; end
                1: begin valid_x = 1'b1; op = OP_RTYPE; alu_op = ALU_MUL; flush_x = 1'b1; end
                default: begin
                    valid_x = 1'b1;
                    flush_x = 1'b0;
                    op      = OP_RTYPE;
                    alu_op  = 5'($urandom_range(8, 31));
                end
            endcase
            #1;
            chk(stall == 1'b0, "idle_stall", 64'(stall), 64'd0);
            @(negedge clock);
        end
        valid_x = 1'b0;
        flush_x = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b;
        bit          is_div;
        repeat (3) @(negedge clock);
        #1;
        chk({stall, md_ready, md_we, md_exception, md_rd, md_result} == 41'd0, "reset_state",
            64'({stall, md_ready, md_we, md_exception, md_rd, md_result}), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        mon_en = 1'b1;

        run_op(1'b0, 32'd7, 32'hFFFF_FFFA, 5'd5, -1, -1);
        run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 5'd3, -1, -1);
        run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 5'd9, -1, -1);
        run_op(1'b1, 32'd5, 32'd0, 5'd4, -1, -1);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, -1, -1);
        run_op(1'b0, 32'd3, 32'd4, 5'd0, -1, -1);
        run_op(1'b1, 32'd0, 32'd9, 5'd11, -1, -1);
        idle_cycles(2);
        run_op(1'b0, 32'd123, 32'd456, 5'd7, 10, -1);
        idle_cycles(40);
        run_op(1'b1, 32'd1000, 32'd3, 5'd8, -1, 20);
        idle_cycles(40);

        for (int n = 0; n < 30; n++) begin
            is_div = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: ;
                1: begin
                    a = 32'($urandom_range(0, 2000)) - 32'd1000;
                    b = 32'($urandom_range(0, 60)) - 32'd30;
                end
                2: begin a = 32'd0; if (b == 32'd0) b = 32'd1; end
                3: b = 32'd0;
                4: begin a = 32'h8000_0000; b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'd1; end
                default: begin
                    a = 32'($urandom_range(0, 65535)) << $urandom_range(0, 16);
                    b = 32'($urandom_range(0, 65535)) << $urandom_range(0, 16);
                end
            endcase
            run_op(is_div, a, b, 5'($urandom_range(0, 31)), -1, -1);
            if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)));
        end

        idle_cycles(3);
        chk(sb_q.size() == 0, "pending_writebacks", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
